// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: fetch-stage PC, imem handshake, one-entry skid and IF/ID register; IF_STAGE_PERF_CNT_EN adds stall/flush counters
module if_stage_ctrl #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              if_id_flush,
    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc4, skid_pc4;
    logic [DATA_W-1:0] skid_instr;
    logic kill, take_f, take_h, bubble, skid_load;
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign imem_addr  = pc;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;
    always_comb begin
        state_n = (redirect_vld || if_id_flush || state == IDLE) ? FETCH :
                  (state == FETCH) ? ((imem_rdy && !if_id_write) ? HOLD : FETCH) :
                  (if_id_write ? FETCH : HOLD);
    end
    always_comb begin
        imem_req = (state == FETCH);
    end
    // Redirect and flush kill both the live response and the skid entry.
    always_comb begin
        kill      = redirect_vld || if_id_flush;
        take_f    = state == FETCH && imem_rdy && if_id_write && !kill;
        take_h    = state == HOLD && if_id_write && !kill;
        bubble    = kill || (state == FETCH && !imem_rdy && if_id_write);
        skid_load = state == FETCH && imem_rdy && !if_id_write && !kill;
        pc4       = pc + ADDR_W'(4);
        pc_n      = redirect_vld ? {redirect_pc[ADDR_W-1:2], 2'b00} :
                    ((take_f || take_h) && pc_write) ? pc4 : pc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            skid_instr  <= NOP_INSTR;
            skid_pc4    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            pc <= pc_n;
            if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc4;
            end
            if (bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (take_f) begin
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc4;
                if_id_valid <= 1'b1;
            end else if (take_h) begin
                if_id_instr <= skid_instr;
                if_id_pc4   <= skid_pc4;
                if_id_valid <= 1'b1;
            end
        end
    end
`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!if_id_write && state != IDLE && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (kill && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb_if_stage_ctrl: directed fetch sequence with a scoreboard of IF/ID loads; honours IF_STAGE_PERF_CNT_EN
module tb_if_stage_ctrl;
    typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} ent_t;
    localparam int LOAD = 0, BUB = 1, KEEP = 2;
    logic clk = 1'b0, reset = 1'b1;
    logic pc_write = 1'b1, if_id_write = 1'b1, if_id_flush = 1'b0, redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic imem_req, imem_rdy = 1'b1, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4, perf_stall_cnt, perf_flush_cnt;
    ent_t q[$];
    ent_t e;
    int passed = 0, total = 0;
    logic [31:0] last_instr = '0, last_pc4 = '0;
    logic last_valid = 1'b0;
    if_stage_ctrl dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction
    assign imem_rdata = mem(imem_addr);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic push(input logic [31:0] pc);
        q.push_back('{instr: mem(pc), pc4: pc + 32'd4});
    endtask
    task automatic cyc(input int kind, input logic [31:0] exp_pc, input logic exp_req);
        @(posedge clk);
        #1;
        if (kind == LOAD) begin
            if (q.size() == 0) begin
                total++;
                $error("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e = q.pop_front();
                last_instr = e.instr;
                last_pc4   = e.pc4;
                last_valid = 1'b1;
            end
        end else if (kind == BUB) begin
            last_instr = '0;
            last_valid = 1'b0;
        end
        chk("valid", {31'd0, if_id_valid}, {31'd0, last_valid});
        chk("instr", if_id_instr, last_instr);
        if (kind != BUB) chk("pc4", if_id_pc4, last_pc4);
        chk("imem_addr", imem_addr, exp_pc);
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    endtask
    task automatic chk_cnt(input logic [31:0] s, input logic [31:0] f);
`ifdef IF_STAGE_PERF_CNT_EN
        chk("stall_cnt", perf_stall_cnt, s);
        chk("flush_cnt", perf_flush_cnt, f);
`else
        chk("stall_cnt", perf_stall_cnt, s & 32'd0);
        chk("flush_cnt", perf_flush_cnt, f & 32'd0);
`endif
    endtask
    initial begin
        @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        chk_cnt(0, 0);
        reset = 1'b0;
        cyc(KEEP, 32'h0, 1'b1);
        push(32'h0); cyc(LOAD, 32'h4, 1'b1);
        push(32'h4); cyc(LOAD, 32'h8, 1'b1);
        pc_write = 1'b0; if_id_write = 1'b0;
        cyc(KEEP, 32'h8, 1'b0);
        pc_write = 1'b1; if_id_write = 1'b1;
        push(32'h8); cyc(LOAD, 32'hC, 1'b1);
        imem_rdy = 1'b0;
        repeat (3) cyc(BUB, 32'hC, 1'b1);
        imem_rdy = 1'b1; pc_write = 1'b0; if_id_write = 1'b0;
        cyc(KEEP, 32'hC, 1'b0);
        redirect_vld = 1'b1; redirect_pc = 32'h0000_0043;
        cyc(BUB, 32'h40, 1'b1);
        redirect_vld = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        push(32'h40); cyc(LOAD, 32'h44, 1'b1);
        if_id_flush = 1'b1;
        cyc(BUB, 32'h44, 1'b1);
        if_id_flush = 1'b0;
        push(32'h44); cyc(LOAD, 32'h48, 1'b1);
        imem_rdy = 1'b0; if_id_write = 1'b0;
        repeat (2) cyc(KEEP, 32'h48, 1'b1);
        chk_cnt(5, 2);
        imem_rdy = 1'b1; if_id_write = 1'b1;
        redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(BUB, 32'hFFFF_FFFC, 1'b1);
        redirect_vld = 1'b0;
        push(32'hFFFF_FFFC); cyc(LOAD, 32'h0, 1'b1);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk_cnt(5, 3);
        chk("sb_empty", q.size(), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mid_rst_instr", if_id_instr, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'd0);
        chk_cnt(0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
